cache_ctrl: RTL and testbench



---
 rtl/cache_ctrl.sv | 147 ++++++++++++++
 tb/tb_cache_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through / no-write-allocate controller for an 8-line x 8-bit data array.
// Optional hit/miss statistics counters are built when CACHE_STATS_EN is defined.
module cache_ctrl #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_ready,
    output logic              busy,
    input  logic              flush,
    output logic [2:0]        cm_addr,
    output logic              cm_rd,
    output logic              cm_wr,
    output logic [7:0]        cm_wdata,
    input  logic [7:0]        cm_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    localparam int TAG_W = ADDR_W - 3;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        RD_WAIT,
        MISS,
        FILL,
        WR_MEM
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] req_addr;
    logic              req_we;
    logic [7:0]        req_wdata;
    logic [7:0]        fill_data;
    logic [7:0]        valid;
    logic [TAG_W-1:0]  tags [8];

    logic [2:0]        idx;
    logic [TAG_W-1:0]  req_tag;
    logic              hit;

    assign idx     = req_addr[2:0];
    assign req_tag = req_addr[ADDR_W-1:3];
    assign hit     = valid[idx] && (tags[idx] == req_tag);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            req_addr  <= '0;
            req_we    <= 1'b0;
            req_wdata <= '0;
            fill_data <= '0;
            valid     <= '0;
            for (int i = 0; i < 8; i++) tags[i] <= '0;
            cpu_rdata <= '0;
            cpu_ready <= 1'b0;
        end else begin
            cpu_ready <= 1'b0;
            case (state)
                IDLE: begin
                    // Flush wins over a simultaneous request, which stays pending.
                    if (flush) begin
                        valid <= '0;
                    end else if (cpu_req) begin
                        req_addr  <= cpu_addr;
                        req_we    <= cpu_we;
                        req_wdata <= cpu_wdata;
                        state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (req_we)   state <= WR_MEM;
                    else if (hit) state <= RD_WAIT;
                    else          state <= MISS;
                end
                RD_WAIT: begin
                    cpu_rdata <= cm_rdata;
                    cpu_ready <= 1'b1;
                    state     <= IDLE;
                end
                MISS: begin
                    if (mem_ack) begin
                        fill_data <= mem_rdata;
                        state     <= FILL;
                    end
                end
                FILL: begin
                    tags[idx]  <= req_tag;
                    valid[idx] <= 1'b1;
                    cpu_rdata  <= fill_data;
                    cpu_ready  <= 1'b1;
                    state      <= IDLE;
                end
                WR_MEM: begin
                    if (mem_ack) begin
                        cpu_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == LOOKUP) begin
            if (hit) begin
                if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
            end else begin
                if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
            end
        end
    end
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

    // Strobes decode straight from state so a reset drops them immediately.
    assign busy      = (state != IDLE);
    assign cm_addr   = idx;
    assign cm_rd     = (state == LOOKUP) && !req_we && hit;
    assign cm_wr     = ((state == LOOKUP) && req_we && hit) || (state == FILL);
    assign cm_wdata  = (state == FILL) ? fill_data : req_wdata;
    assign mem_req   = (state == MISS) || (state == WR_MEM);
    assign mem_we    = (state == WR_MEM);
    assign mem_addr  = req_addr;
    assign mem_wdata = req_wdata;

endmodule

// File: tb/tb_cache_ctrl.sv
// Scoreboard bench for cache_ctrl with a data-array model and a delayed-ack memory responder.
module tb_cache_ctrl;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [7:0]  cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ready;
    logic        busy;
    logic        flush;
    logic [2:0]  cm_addr;
    logic        cm_rd;
    logic        cm_wr;
    logic [7:0]  cm_wdata;
    logic [7:0]  cm_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    cache_ctrl #(.ADDR_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .busy(busy), .flush(flush),
        .cm_addr(cm_addr), .cm_rd(cm_rd), .cm_wr(cm_wr), .cm_wdata(cm_wdata), .cm_rdata(cm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    int total = 0;
    int bad   = 0;
    int ack_delay = 1;
    int wait_cnt  = 0;
    int overlap_err = 0;

    logic [7:0] ref_mem   [256];
    logic [7:0] mem_store [256];
    logic [7:0] arr       [8];
    logic       m_valid   [8];
    logic [4:0] m_tag     [8];
    int         m_hits = 0;
    int         m_misses = 0;
    logic [7:0] last_rd = 8'h00;
    logic [7:0] exp_q [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Data array: write commits on negedge, read data registered on posedge.
    always @(negedge clk) if (cm_wr) arr[cm_addr] <= cm_wdata;
    always @(posedge clk) if (cm_rd) cm_rdata <= arr[cm_addr];
    always @(negedge clk) if (cm_rd && cm_wr) overlap_err <= overlap_err + 1;

    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end else begin
                #1;
                if (mem_ack) begin
                    mem_ack  = 1'b0;
                    wait_cnt = 0;
                end else if (mem_req) begin
                    wait_cnt++;
                    if (wait_cnt >= ack_delay) begin
                        mem_ack = 1'b1;
                        if (mem_we) mem_store[mem_addr] = mem_wdata;
                        else        mem_rdata = mem_store[mem_addr];
                    end
                end else begin
                    wait_cnt = 0;
                end
            end
        end
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_counters(input string tag);
`ifdef CACHE_STATS_EN
        check_output({tag, "_hitcnt"}, {16'h0, hit_cnt}, m_hits);
        check_output({tag, "_misscnt"}, {16'h0, miss_cnt}, m_misses);
`else
        check_output({tag, "_hitcnt"}, {16'h0, hit_cnt}, 0);
        check_output({tag, "_misscnt"}, {16'h0, miss_cnt}, 0);
`endif
    endtask

    task automatic apply_stimulus(input string tag, input bit we, input logic [7:0] addr,
                                  input logic [7:0] wdata, input int delay, input bit with_flush);
        bit         exp_hit;
        int         cycles;
        int         exp_lat;
        bit         saw_req, saw_rd, saw_wr;
        logic [7:0] seen_addr, wr_data;
        logic       seen_we;
        logic [2:0] wr_idx;
        logic [7:0] exp_data;

        ack_delay = delay;
        if (with_flush) for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
        exp_hit = m_valid[addr[2:0]] && (m_tag[addr[2:0]] == addr[7:3]);
        if (exp_hit) m_hits++; else m_misses++;
        if (we) begin
            ref_mem[addr] = wdata;
            exp_q.push_back(last_rd);
        end else begin
            last_rd = ref_mem[addr];
            exp_q.push_back(ref_mem[addr]);
            if (!exp_hit) begin
                m_valid[addr[2:0]] = 1'b1;
                m_tag[addr[2:0]]   = addr[7:3];
            end
        end

        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        if (with_flush) begin
            flush = 1'b1;
            @(posedge clk); #1;
            check_output({tag, "_flush_block"}, {31'h0, busy}, 0);
            flush = 1'b0;
        end
        @(posedge clk); #1;
        cpu_req = 1'b0;

        cycles = 1; saw_req = 0; saw_rd = 0; saw_wr = 0;
        seen_addr = 8'h00; seen_we = 1'b0; wr_data = 8'h00; wr_idx = 3'h0;
        while (!cpu_ready && cycles < 60) begin
            if (mem_req) begin saw_req = 1; seen_addr = mem_addr; seen_we = mem_we; end
            if (cm_rd) saw_rd = 1;
            if (cm_wr) begin saw_wr = 1; wr_data = cm_wdata; wr_idx = cm_addr; end
            @(posedge clk); #1;
            cycles++;
        end
        if (!cpu_ready) begin
            check_output({tag, "_timeout"}, 0, 1);
            return;
        end

        if (exp_q.size() == 0) begin
            check_output({tag, "_sb_empty"}, 0, 1);
        end else begin
            exp_data = exp_q.pop_front();
            check_output({tag, "_rdata"}, {24'h0, cpu_rdata}, {24'h0, exp_data});
        end
        exp_lat = we ? (2 + delay) : (exp_hit ? 3 : (3 + delay));
        check_output({tag, "_latency"}, cycles, exp_lat);
        check_output({tag, "_memreq"}, {31'h0, saw_req}, {31'h0, (we || !exp_hit)});
        if (saw_req) begin
            check_output({tag, "_memaddr"}, {24'h0, seen_addr}, {24'h0, addr});
            check_output({tag, "_memwe"}, {31'h0, seen_we}, {31'h0, we});
        end
        check_output({tag, "_cmrd"}, {31'h0, saw_rd}, {31'h0, (!we && exp_hit)});
        check_output({tag, "_cmwr"}, {31'h0, saw_wr}, {31'h0, (we ? exp_hit : !exp_hit)});
        if (saw_wr) begin
            check_output({tag, "_cmwdata"}, {24'h0, wr_data}, {24'h0, ref_mem[addr]});
            check_output({tag, "_cmidx"}, {29'h0, wr_idx}, {29'h0, addr[2:0]});
        end
        if (we && saw_req)
            check_output({tag, "_memstore"}, {24'h0, mem_store[addr]}, {24'h0, wdata});
        check_counters(tag);
        @(posedge clk); #1;
        check_output({tag, "_ready_pulse"}, {31'h0, cpu_ready}, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            ref_mem[i]   = 8'(i) ^ 8'hA5;
            mem_store[i] = 8'(i) ^ 8'hA5;
        end
        ref_mem[8'h2A] = 8'h5C; mem_store[8'h2A] = 8'h5C;
        for (int i = 0; i < 8; i++) begin m_valid[i] = 1'b0; m_tag[i] = 5'h0; end

        rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_rdata", {24'h0, cpu_rdata}, 0);
        check_output("rst_ready", {31'h0, cpu_ready}, 0);
        check_output("rst_busy", {31'h0, busy}, 0);
        check_output("rst_cm", {18'h0, cm_rd, cm_wr, cm_addr, cm_wdata}, 0);
        check_output("rst_mem", {14'h0, mem_req, mem_we, mem_addr, mem_wdata}, 0);
        check_counters("rst");
        rst = 1'b1;

        apply_stimulus("rd2a_miss",  1'b0, 8'h2A, 8'h00, 2, 1'b0);
        apply_stimulus("rd2a_hit",   1'b0, 8'h2A, 8'h00, 1, 1'b0);
        apply_stimulus("rd32_miss",  1'b0, 8'h32, 8'h00, 1, 1'b0);
        apply_stimulus("rd2a_evict", 1'b0, 8'h2A, 8'h00, 3, 1'b0);
        apply_stimulus("wr2a_hit",   1'b1, 8'h2A, 8'h11, 1, 1'b0);
        apply_stimulus("wr7f_miss",  1'b1, 8'h7F, 8'h66, 2, 1'b0);
        apply_stimulus("rd2a_new",   1'b0, 8'h2A, 8'h00, 1, 1'b0);
        apply_stimulus("rd7f_miss",  1'b0, 8'h7F, 8'h00, 1, 1'b0);
        apply_stimulus("rd7f_hit",   1'b0, 8'h7F, 8'h00, 1, 1'b0);
        apply_stimulus("flush_rd2a", 1'b0, 8'h2A, 8'h00, 1, 1'b1);

        // Abort a miss with reset while mem_req is outstanding.
        ack_delay = 30;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h42;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        for (int i = 0; i < 10 && !mem_req; i++) begin @(posedge clk); #1; end
        check_output("abort_memreq_up", {31'h0, mem_req}, 1);
        #2 rst = 1'b0;
        #1;
        check_output("abort_memreq", {31'h0, mem_req}, 0);
        check_output("abort_busy", {31'h0, busy}, 0);
        check_output("abort_ready", {31'h0, cpu_ready}, 0);
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
        m_hits = 0; m_misses = 0; last_rd = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_output("abort_no_ready", {31'h0, cpu_ready}, 0);
        check_counters("abort");
        rst = 1'b1;

        apply_stimulus("post_rst_rd2a", 1'b0, 8'h2A, 8'h00, 1, 1'b0);
        apply_stimulus("post_rst_hit",  1'b0, 8'h2A, 8'h00, 1, 1'b0);

        check_output("strobe_excl", overlap_err, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
